// File: rtl/z80bd_pkg.sv
// z80bd_pkg: shared I/O map, interrupt source indices and NMI debounce states for the Z80 board.
package z80bd_pkg;
   localparam logic [7:0] PORT_MAP_0    = 8'h10;
   localparam logic [7:0] PORT_MAP_1    = 8'h11;
   localparam logic [7:0] PORT_MAP_2    = 8'h12;
   localparam logic [7:0] PORT_MAP_3    = 8'h13;
   localparam logic [7:0] PORT_INT_MASK = 8'h14;
   localparam logic [7:0] PORT_INT_PEND = 8'h15;
   localparam logic [7:0] PORT_INT_VEC  = 8'h16;
   localparam logic [7:0] PORT_TMR_DIV  = 8'h17;

   localparam logic [1:0] SRC_TIMER = 2'd0;
   localparam logic [1:0] SRC_UART  = 2'd1;
   localparam logic [1:0] SRC_SOFT  = 2'd2;

   typedef enum logic [1:0] {NMI_ARMED, NMI_LOW, NMI_REARM} nmi_state_t;

   // uart > timer > soft; with nothing requesting, keep the previous choice
   function automatic logic [1:0] prio_idx(input logic [2:0] req, input logic [1:0] cur);
      return req[SRC_UART] ? SRC_UART : req[SRC_TIMER] ? SRC_TIMER : req[SRC_SOFT] ? SRC_SOFT : cur;
   endfunction
endpackage

// File: rtl/z80bd_tick_timer.sv
// z80bd_tick_timer: PRESC-clock prescaler feeding a reloadable 8-bit down-counter; expire pulses on 1->0.
module z80bd_tick_timer
#(
   parameter int PRESC       = 24000,
   parameter int TMR_DIV_RST = 20
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic [7:0] div,
   output logic       expire
);
   localparam int PW = PRESC > 1 ? $clog2(PRESC) : 1;
   logic [PW-1:0] pre;
   logic [7:0]    cnt;
   logic          tick;

   assign tick   = pre == PW'(PRESC - 1);
   assign expire = tick & (cnt == 8'd1) & ~load;

   // a count of 0 leaves the timer idle until the next load
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pre <= '0;
         cnt <= 8'(TMR_DIV_RST);
      end else if (load) begin
         pre <= '0;
         cnt <= load_val;
      end else begin
         pre <= tick ? '0 : pre + 1'b1;
         if (tick && cnt != 8'd0) cnt <= cnt == 8'd1 ? div : cnt - 8'd1;
      end
endmodule

// File: rtl/z80bd_int_ctrl.sv
// z80bd_int_ctrl: timer/uart/soft interrupt aggregation onto INT with IM2 vector, ports 0x14..0x17.
// Debounced NMI button is built only when Z80BD_NMI_EN is defined; otherwise NMI stays high.
module z80bd_int_ctrl
   import z80bd_pkg::*;
#(
   parameter int PRESC       = 24000,
   parameter int TMR_DIV_RST = 20
`ifdef Z80BD_NMI_EN
   ,
   parameter int NMI_DEB     = 240000,
   parameter int NMI_PULSE   = 64
`endif
)
(
   input  logic       CLK_24MHz,
   input  logic       RES,
   input  logic       IORQ,
   input  logic       M1,
   input  logic       RD,
   input  logic       WR,
   input  logic [7:0] A,
   input  logic [7:0] D_IN,
   output logic [7:0] D_OUT,
   output logic       D_OE,
   input  logic       U_INT,
   input  logic       NMI_BTN,
   output logic       INT,
   output logic       NMI
);
   logic [1:0] iorq_q, m1_q, wr_q, uint_q;
   logic       iowr_p, intack_p;
   logic [2:0] mask, mask_d, pend;
   logic [4:0] vec;
   logic [7:0] tmr_div;
   logic       tmr_p, tmr_d, soft_p, soft_d;
   logic [1:0] ack_idx;
   logic       iowr_s, io_wr, intack_s, ack_rise;
   logic       wr_mask, wr_pend, wr_vec, wr_div;
   logic       expire, intack, io_rd;

   assign iowr_s   = iorq_q[1] | wr_q[1];
   assign io_wr    = iowr_p & ~iowr_s;
   assign intack_s = ~m1_q[1] & ~iorq_q[1];
   assign ack_rise = intack_s & ~intack_p;
   assign wr_mask  = io_wr & (A == PORT_INT_MASK);
   assign wr_pend  = io_wr & (A == PORT_INT_PEND);
   assign wr_vec   = io_wr & (A == PORT_INT_VEC);
   assign wr_div   = io_wr & (A == PORT_TMR_DIV);
   assign pend     = {soft_p, uint_q[1], tmr_p};

   z80bd_tick_timer #(.PRESC(PRESC), .TMR_DIV_RST(TMR_DIV_RST)) u_timer (
      .clk(CLK_24MHz), .rst(RES), .load(wr_div), .load_val(D_IN), .div(tmr_div), .expire(expire)
   );

   // sets beat clears; INT is registered from the next-state pending bits
   always_comb begin
      tmr_d  = expire | (tmr_p & ~(wr_pend & D_IN[0]) & ~(ack_rise & ack_idx == SRC_TIMER));
      soft_d = (wr_pend & D_IN[6]) | (soft_p & ~(wr_pend & D_IN[2]) & ~(ack_rise & ack_idx == SRC_SOFT));
      mask_d = wr_mask ? D_IN[2:0] : mask;
   end

   always_ff @(posedge CLK_24MHz or posedge RES)
      if (RES) begin
         iorq_q   <= 2'b11;
         m1_q     <= 2'b11;
         wr_q     <= 2'b11;
         uint_q   <= 2'b00;
         iowr_p   <= 1'b1;
         intack_p <= 1'b0;
         mask     <= '0;
         vec      <= '0;
         tmr_div  <= 8'(TMR_DIV_RST);
         tmr_p    <= 1'b0;
         soft_p   <= 1'b0;
         ack_idx  <= SRC_TIMER;
         INT      <= 1'b1;
      end else begin
         iorq_q   <= {iorq_q[0], IORQ};
         m1_q     <= {m1_q[0], M1};
         wr_q     <= {wr_q[0], WR};
         uint_q   <= {uint_q[0], U_INT};
         iowr_p   <= iowr_s;
         intack_p <= intack_s;
         mask     <= mask_d;
         tmr_p    <= tmr_d;
         soft_p   <= soft_d;
         if (wr_vec) vec <= D_IN[7:3];
         if (wr_div) tmr_div <= D_IN;
         if (m1_q[1]) ack_idx <= prio_idx(pend & mask, ack_idx);
         INT      <= ~|({soft_d, uint_q[1], tmr_d} & mask_d);
      end

   assign intack = ~M1 & ~IORQ;
   assign io_rd  = ~IORQ & ~RD & M1 & (A[7:2] == PORT_INT_MASK[7:2]);
   assign D_OE   = ~RES & (io_rd | intack);
   assign D_OUT  = intack       ? {vec, ack_idx, 1'b0} :
                   A[1:0] == 2'd0 ? {5'b0, mask} :
                   A[1:0] == 2'd1 ? {5'b0, pend} :
                   A[1:0] == 2'd2 ? {vec, 3'b0} : tmr_div;

`ifdef Z80BD_NMI_EN
   logic [1:0] btn_q;
   nmi_state_t state, state_d;
   logic [31:0] cnt, cnt_d;

   always_ff @(posedge CLK_24MHz or posedge RES)
      if (RES) begin
         btn_q <= 2'b11;
         state <= NMI_ARMED;
         cnt   <= '0;
      end else begin
         btn_q <= {btn_q[0], NMI_BTN};
         state <= state_d;
         cnt   <= cnt_d;
      end

   // press needs NMI_DEB low clocks, re-arm needs NMI_DEB high clocks
   always_comb begin
      state_d = state;
      cnt_d   = cnt + 32'd1;
      case (state)
         NMI_ARMED:
            if (btn_q[1]) cnt_d = '0;
            else if (cnt == 32'(NMI_DEB - 1)) begin
               state_d = NMI_LOW;
               cnt_d   = '0;
            end
         NMI_LOW:
            if (cnt == 32'(NMI_PULSE - 1)) begin
               state_d = NMI_REARM;
               cnt_d   = '0;
            end
         default:
            if (!btn_q[1]) cnt_d = '0;
            else if (cnt == 32'(NMI_DEB - 1)) begin
               state_d = NMI_ARMED;
               cnt_d   = '0;
            end
      endcase
   end

   assign NMI = state != NMI_LOW;
`else
   logic unused_nmi_btn;
   assign unused_nmi_btn = NMI_BTN;
   assign NMI = 1'b1;
`endif
endmodule

// File: tb/tb_z80bd_int_ctrl.sv
// tb_z80bd_int_ctrl: directed bus-cycle checks of the interrupt controller (PRESC=4 for a fast timer).
module tb_z80bd_int_ctrl;
   logic       clk = 1'b0;
   logic       RES, IORQ, M1, RD, WR, U_INT, NMI_BTN;
   logic [7:0] A, D_IN, D_OUT;
   logic       D_OE, INT, NMI;
   int         n_chk = 0;
   int         n_err = 0;

   localparam int NMI_PULSE_TB = 16;

   always #5 clk = ~clk;

   z80bd_int_ctrl #(
      .PRESC(4), .TMR_DIV_RST(20)
`ifdef Z80BD_NMI_EN
      , .NMI_DEB(8), .NMI_PULSE(NMI_PULSE_TB)
`endif
   ) dut (
      .CLK_24MHz(clk), .RES(RES), .IORQ(IORQ), .M1(M1), .RD(RD), .WR(WR), .A(A), .D_IN(D_IN),
      .D_OUT(D_OUT), .D_OE(D_OE), .U_INT(U_INT), .NMI_BTN(NMI_BTN), .INT(INT), .NMI(NMI)
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic io_wr(input logic [7:0] addr, input logic [7:0] data);
      A = addr;
      D_IN = data;
      IORQ = 1'b0;
      WR = 1'b0;
      tick(3);
      IORQ = 1'b1;
      WR = 1'b1;
      tick(3);
   endtask

   task automatic io_rd(input string tag, input logic [7:0] addr, input logic [7:0] exp);
      A = addr;
      IORQ = 1'b0;
      RD = 1'b0;
      #1;
      chk({tag, "_oe"}, {7'b0, D_OE}, 8'h01);
      chk(tag, D_OUT, exp);
      IORQ = 1'b1;
      RD = 1'b1;
      #1;
   endtask

   task automatic ack_begin();
      M1 = 1'b0;
      tick(3);
      IORQ = 1'b0;
      #1;
   endtask

   task automatic ack_end();
      IORQ = 1'b1;
      M1 = 1'b1;
      tick(3);
   endtask

   initial begin
      RES = 1'b1; IORQ = 1'b1; M1 = 1'b1; RD = 1'b1; WR = 1'b1;
      A = 8'h00; D_IN = 8'h00; U_INT = 1'b0; NMI_BTN = 1'b1;
      tick(3);
      chk("rst_int", {7'b0, INT}, 8'h01);
      chk("rst_oe", {7'b0, D_OE}, 8'h00);
      chk("rst_nmi", {7'b0, NMI}, 8'h01);
      RES = 1'b0;
      tick(2);
      io_rd("rst_mask", 8'h14, 8'h00);
      io_rd("rst_pend", 8'h15, 8'h00);
      io_rd("rst_vec", 8'h16, 8'h00);
      io_rd("rst_div", 8'h17, 8'd20);

      // timer: write lands 3 clocks into io_wr, io_wr returns 3 clocks after that
      io_wr(8'h14, 8'h01);
      io_wr(8'h17, 8'h03);
      tick(8);
      chk("tmr_int_hi_11", {7'b0, INT}, 8'h01);
      tick(1);
      chk("tmr_int_lo_12", {7'b0, INT}, 8'h00);
      io_rd("tmr_pend", 8'h15, 8'h01);
      io_wr(8'h17, 8'h00);
      io_rd("tmr_div0", 8'h17, 8'h00);

      // uart outranks timer
      U_INT = 1'b1;
      io_wr(8'h14, 8'h03);
      io_wr(8'h16, 8'hA0);
      chk("uart_int", {7'b0, INT}, 8'h00);
      M1 = 1'b0;
      #1;
      chk("mem_m1_oe", {7'b0, D_OE}, 8'h00);
      M1 = 1'b1;
      ack_begin();
      chk("uart_ack_oe", {7'b0, D_OE}, 8'h01);
      chk("uart_ack_vec", D_OUT, 8'hA2);
      tick(4);
      ack_end();
      io_rd("uart_pend", 8'h15, 8'h03);
      chk("uart_int_held", {7'b0, INT}, 8'h00);
      U_INT = 1'b0;
      tick(4);
      io_rd("uart_gone_pend", 8'h15, 8'h01);
      chk("tmr_int_still", {7'b0, INT}, 8'h00);

      // timer acknowledge clears timer pending
      ack_begin();
      chk("tmr_ack_vec", D_OUT, 8'hA0);
      tick(4);
      chk("tmr_ack_int", {7'b0, INT}, 8'h01);
      ack_end();
      io_rd("tmr_ack_pend", 8'h15, 8'h00);

      // soft set/clear, vector low bits dropped
      io_wr(8'h15, 8'h44);
      io_rd("soft_set_wins", 8'h15, 8'h04);
      io_wr(8'h15, 8'h04);
      io_rd("soft_clr", 8'h15, 8'h00);
      io_wr(8'h16, 8'hA7);
      io_rd("vec_mask", 8'h16, 8'hA0);
      io_wr(8'h14, 8'h04);
      io_wr(8'h15, 8'h40);
      chk("soft_int", {7'b0, INT}, 8'h00);
      ack_begin();
      chk("soft_ack_vec", D_OUT, 8'hA4);
      tick(4);
      chk("soft_ack_int", {7'b0, INT}, 8'h01);
      ack_end();
      io_rd("soft_ack_pend", 8'h15, 8'h00);
      ack_begin();
      chk("empty_ack_vec", D_OUT, 8'hA4);
      ack_end();
      chk("empty_ack_int", {7'b0, INT}, 8'h01);

      // reset during acknowledge
      io_wr(8'h15, 8'h40);
      io_wr(8'h14, 8'h07);
      chk("pre_rst_int", {7'b0, INT}, 8'h00);
      ack_begin();
      chk("pre_rst_oe", {7'b0, D_OE}, 8'h01);
      RES = 1'b1;
      #1;
      chk("midack_oe", {7'b0, D_OE}, 8'h00);
      chk("midack_int", {7'b0, INT}, 8'h01);
      chk("midack_nmi", {7'b0, NMI}, 8'h01);
      tick(2);
      RES = 1'b0;
      ack_end();
      io_rd("post_rst_mask", 8'h14, 8'h00);
      io_rd("post_rst_vec", 8'h16, 8'h00);
      io_rd("post_rst_div", 8'h17, 8'd20);
      io_rd("post_rst_pend", 8'h15, 8'h00);

`ifdef Z80BD_NMI_EN
      begin
         int low_cnt;
         int falls;
         logic prev;
         NMI_BTN = 1'b0;
         tick(5);
         NMI_BTN = 1'b1;
         low_cnt = 0;
         for (int i = 0; i < 40; i++) begin
            tick(1);
            if (!NMI) low_cnt++;
         end
         chk("nmi_glitch", 8'(low_cnt), 8'd0);
         NMI_BTN = 1'b0;
         low_cnt = 0;
         falls = 0;
         prev = 1'b1;
         for (int i = 0; i < 100; i++) begin
            if (i == 10) NMI_BTN = 1'b1;
            tick(1);
            if (!NMI) low_cnt++;
            if (prev && !NMI) falls++;
            prev = NMI;
         end
         chk("nmi_pulse_len", 8'(low_cnt), 8'(NMI_PULSE_TB));
         chk("nmi_pulse_once", 8'(falls), 8'd1);
      end
`else
      NMI_BTN = 1'b0;
      tick(4);
      chk("nmi_tied", {7'b0, NMI}, 8'h01);
      NMI_BTN = 1'b1;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
